// File: rtl/onehot_register_file.sv
// 16 x N register file written through a one-hot select vector, with two combinational read
// ports, a per-register written bitmap, a sticky illegal-select flag and a saturating write counter.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module onehot_register_file #(
    parameter int N        = 32,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [15:0]  wr_sel,
    input  logic [N-1:0] wr_data,
    input  logic [3:0]   rd_addr0,
    input  logic [3:0]   rd_addr1,
    output logic [N-1:0] rd_data0,
    output logic [N-1:0] rd_data1,
    output logic         rd_valid0,
    output logic         rd_valid1,
    output logic         wr_err,
    output logic [7:0]   wr_count
);

    logic [N-1:0] regs_q [16];
    logic [N-1:0] regs_d [16];
    logic [15:0]  written_q, written_d;
    logic         wr_err_q, wr_err_d;
    logic [7:0]   wr_count_q, wr_count_d;

    logic [4:0]   sel_ones;
    logic         sel_legal;
    logic         sel_illegal;
    logic [15:0]  commit_mask;

    always_comb begin
        sel_ones = '0;
        for (int k = 0; k < 16; k++) begin
            sel_ones = sel_ones + 5'(wr_sel[k]);
        end
        sel_legal   = wr_ena && (sel_ones == 5'd1);
        sel_illegal = wr_ena && (sel_ones > 5'd1);
        commit_mask = sel_legal ? wr_sel : 16'h0000;
        // A write to the hardwired zero register still counts, but stores nothing.
        if (ZERO_REG != 0) begin
            commit_mask[0] = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < 16; k++) begin
            if (commit_mask[k]) begin
                regs_d[k] = wr_data;
            end
        end
        written_d  = written_q | commit_mask;
        wr_err_d   = wr_err_q | sel_illegal;
        wr_count_d = wr_count_q;
        if (sel_legal && (wr_count_q != 8'hFF)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 16; k++) begin
                regs_q[k] <= '0;
            end
            written_q  <= '0;
            wr_err_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            written_q  <= written_d;
            wr_err_q   <= wr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    logic [15:0] byp_mask;

    // Forwarding is suppressed while reset is held so outputs stay at zero.
    assign byp_mask = rst ? commit_mask : 16'h0000;

    always_comb begin
        rd_data0  = regs_q[rd_addr0];
        rd_valid0 = written_q[rd_addr0];
        rd_data1  = regs_q[rd_addr1];
        rd_valid1 = written_q[rd_addr1];
        if (byp_mask[rd_addr0]) begin
            rd_data0  = wr_data;
            rd_valid0 = 1'b1;
        end
        if (byp_mask[rd_addr1]) begin
            rd_data1  = wr_data;
            rd_valid1 = 1'b1;
        end
    end
`else
    always_comb begin
        rd_data0  = regs_q[rd_addr0];
        rd_valid0 = written_q[rd_addr0];
        rd_data1  = regs_q[rd_addr1];
        rd_valid1 = written_q[rd_addr1];
    end
`endif

    assign wr_err   = wr_err_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_onehot_register_file.sv
// Table-driven bench for onehot_register_file: vector records go through a scoreboard queue,
// plus hand-written reset, saturation and asynchronous-reset sequences.
module tb_onehot_register_file;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_ena;
    logic [15:0] wr_sel;
    logic [31:0] wr_data;
    logic [3:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_data0, rd_data1, z_rd_data0, z_rd_data1;
    logic        rd_valid0, rd_valid1, z_rd_valid0, z_rd_valid1;
    logic        wr_err, z_wr_err;
    logic [7:0]  wr_count, z_wr_count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    onehot_register_file #(.N(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .rd_valid0(rd_valid0), .rd_valid1(rd_valid1), .wr_err(wr_err), .wr_count(wr_count)
    );

    onehot_register_file #(.N(32), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(z_rd_data0), .rd_data1(z_rd_data1),
        .rd_valid0(z_rd_valid0), .rd_valid1(z_rd_valid1), .wr_err(z_wr_err), .wr_count(z_wr_count)
    );

    typedef struct {
        logic        ena;
        logic [15:0] sel;
        logic [31:0] data;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [31:0] e_rd0;
        logic        e_v0;
        logic [31:0] e_rd1;
        logic        e_v1;
        logic        e_err;
        logic [7:0]  e_cnt;
        logic        chk_z;
        logic [31:0] e_z_rd0;
        logic        e_z_v0;
        logic [31:0] e_z_rd1;
        logic        e_z_v1;
        logic        chk_pre;
        logic [31:0] pre_rd0;
        logic        pre_v0;
    } vec_t;

    vec_t tbl[11];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic ena, input logic [15:0] sel, input logic [31:0] data,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [31:0] e_rd0, input logic e_v0,
                                input logic [31:0] e_rd1, input logic e_v1,
                                input logic e_err, input logic [7:0] e_cnt);
        vec_t v;
        v.ena = ena; v.sel = sel; v.data = data; v.a0 = a0; v.a1 = a1;
        v.e_rd0 = e_rd0; v.e_v0 = e_v0; v.e_rd1 = e_rd1; v.e_v1 = e_v1;
        v.e_err = e_err; v.e_cnt = e_cnt;
        v.chk_z = 1'b0; v.e_z_rd0 = '0; v.e_z_v0 = 1'b0; v.e_z_rd1 = '0; v.e_z_v1 = 1'b0;
        v.chk_pre = 1'b0; v.pre_rd0 = '0; v.pre_v0 = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // {ena, sel, data, a0, a1, rd0, v0, rd1, v1, err, cnt} after the edge
        tbl[0]  = mk(1, 16'h0020, 32'hDEADBEEF, 5, 15, 32'hDEADBEEF, 1, 32'h0, 0, 0, 8'd1);
        tbl[0].chk_pre = 1'b1;
        tbl[0].pre_rd0 = BYP ? 32'hDEADBEEF : 32'h0;
        tbl[0].pre_v0  = BYP;
        tbl[1]  = mk(1, 16'h8000, 32'h00001111, 15, 5, 32'h00001111, 1, 32'hDEADBEEF, 1, 0, 8'd2);
        tbl[2]  = mk(1, 16'h0000, 32'h0000AAAA, 5, 15, 32'hDEADBEEF, 1, 32'h00001111, 1, 0, 8'd2);
        tbl[3]  = mk(0, 16'hFFFF, 32'h0000BBBB, 3, 15, 32'h0, 0, 32'h00001111, 1, 0, 8'd2);
        tbl[4]  = mk(1, 16'h0001, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 32'h0, 0, 0, 8'd3);
        tbl[4].chk_z = 1'b1;
        tbl[4].e_z_rd0 = 32'hFFFFFFFF; tbl[4].e_z_v0 = 1'b1;
        tbl[4].e_z_rd1 = 32'hFFFFFFFF; tbl[4].e_z_v1 = 1'b1;
        tbl[5]  = mk(1, 16'h0010, 32'h44444444, 4, 5, 32'h44444444, 1, 32'hDEADBEEF, 1, 0, 8'd4);
        tbl[6]  = mk(1, 16'h0030, 32'h12345678, 4, 5, 32'h44444444, 1, 32'hDEADBEEF, 1, 1, 8'd4);
        tbl[7]  = mk(1, 16'h0004, 32'h22222222, 2, 4, 32'h22222222, 1, 32'h44444444, 1, 1, 8'd5);
        tbl[7].chk_pre = 1'b1;
        tbl[7].pre_rd0 = BYP ? 32'h22222222 : 32'h0;
        tbl[7].pre_v0  = BYP;
        tbl[8]  = mk(1, 16'h0008, 32'h33333333, 3, 3, 32'h33333333, 1, 32'h33333333, 1, 1, 8'd6);
        tbl[9]  = mk(1, 16'h0020, 32'h55555555, 5, 0, 32'h55555555, 1, 32'h0, 0, 1, 8'd7);
        tbl[9].chk_z = 1'b1;
        tbl[9].e_z_rd0 = 32'h55555555; tbl[9].e_z_v0 = 1'b1;
        tbl[9].e_z_rd1 = 32'hFFFFFFFF; tbl[9].e_z_v1 = 1'b1;
        tbl[10] = mk(1, 16'hFFFF, 32'h00000000, 5, 2, 32'h55555555, 1, 32'h22222222, 1, 1, 8'd7);

        // Reset held for two cycles
        rst = 1'b0; wr_ena = 1'b0; wr_sel = '0; wr_data = '0; rd_addr0 = 4'd5; rd_addr1 = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset rd_data0", rd_data0, 32'h0);
        chk("in_reset rd_valid1", {31'h0, rd_valid1}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset rd_data0", rd_data0, 32'h0);
        chk("post_reset rd_data1", rd_data1, 32'h0);
        chk("post_reset rd_valid0", {31'h0, rd_valid0}, 32'h0);
        chk("post_reset rd_valid1", {31'h0, rd_valid1}, 32'h0);
        chk("post_reset wr_err", {31'h0, wr_err}, 32'h0);
        chk("post_reset wr_count", {24'h0, wr_count}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            wr_ena = tbl[i].ena; wr_sel = tbl[i].sel; wr_data = tbl[i].data;
            rd_addr0 = tbl[i].a0; rd_addr1 = tbl[i].a1;
            sb_q.push_back(tbl[i]);
            #1;
            if (tbl[i].chk_pre) begin
                chk($sformatf("v%0d pre rd_data0", i), rd_data0, tbl[i].pre_rd0);
                chk($sformatf("v%0d pre rd_valid0", i), {31'h0, rd_valid0}, {31'h0, tbl[i].pre_v0});
            end
            @(posedge clk);
            #1;
            v = sb_q.pop_front();
            chk($sformatf("v%0d rd_data0", i), rd_data0, v.e_rd0);
            chk($sformatf("v%0d rd_valid0", i), {31'h0, rd_valid0}, {31'h0, v.e_v0});
            chk($sformatf("v%0d rd_data1", i), rd_data1, v.e_rd1);
            chk($sformatf("v%0d rd_valid1", i), {31'h0, rd_valid1}, {31'h0, v.e_v1});
            chk($sformatf("v%0d wr_err", i), {31'h0, wr_err}, {31'h0, v.e_err});
            chk($sformatf("v%0d wr_count", i), {24'h0, wr_count}, {24'h0, v.e_cnt});
            if (v.chk_z) begin
                chk($sformatf("v%0d z0 rd_data0", i), z_rd_data0, v.e_z_rd0);
                chk($sformatf("v%0d z0 rd_valid0", i), {31'h0, z_rd_valid0}, {31'h0, v.e_z_v0});
                chk($sformatf("v%0d z0 rd_data1", i), z_rd_data1, v.e_z_rd1);
                chk($sformatf("v%0d z0 rd_valid1", i), {31'h0, z_rd_valid1}, {31'h0, v.e_z_v1});
                chk($sformatf("v%0d z0 wr_err", i), {31'h0, z_wr_err}, {31'h0, v.e_err});
                chk($sformatf("v%0d z0 wr_count", i), {24'h0, z_wr_count}, {24'h0, v.e_cnt});
            end
        end

        // Saturation: count starts at 7, 300 legal writes to register 7
        rd_addr0 = 4'd7; rd_addr1 = 4'd4;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            wr_ena = 1'b1; wr_sel = 16'h0080; wr_data = 32'(1000 + i);
            @(posedge clk);
            #1;
            if (i == 99) chk("sat mid wr_count", {24'h0, wr_count}, 32'd107);
        end
        chk("sat wr_count", {24'h0, wr_count}, 32'd255);
        chk("sat rd_data0", rd_data0, 32'd1299);
        chk("sat wr_err held", {31'h0, wr_err}, 32'h1);
        chk("sat untouched rd_data1", rd_data1, 32'h44444444);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        chk("async rd_data0", rd_data0, 32'h0);
        chk("async rd_valid0", {31'h0, rd_valid0}, 32'h0);
        chk("async rd_data1", rd_data1, 32'h0);
        chk("async wr_err", {31'h0, wr_err}, 32'h0);
        chk("async wr_count", {24'h0, wr_count}, 32'h0);

        // A legal write across an edge with reset held must not commit
        @(negedge clk);
        wr_ena = 1'b1; wr_sel = 16'h0002; wr_data = 32'hCAFEF00D; rd_addr0 = 4'd1;
        #1;
        chk("rst held bypass rd_data0", rd_data0, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        wr_ena = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst edge rd_data0", rd_data0, 32'h0);
        chk("rst edge rd_valid0", {31'h0, rd_valid0}, 32'h0);
        chk("rst edge wr_count", {24'h0, wr_count}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_register_file.md
Name: onehot_register_file

Overview:
- 16-entry x N-bit register file for the RISC-V lab CPU.
- Sits directly downstream of the 4-to-16 write-address decoder and consumes its one-hot 16-bit output as the per-register write-enable vector.
- Provides two combinational read ports and a per-register "written since reset" bitmap.
- Flags illegal (non-one-hot) write-select vectors with a sticky error.

Parameters:
N, 32, data width of each register in bits.
ZERO_REG, 1, when 1 register 0 is hardwired to zero and never written; when 0 register 0 behaves like the others.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
wr_ena  input  1  global write enable for this cycle.
wr_sel  input  16  one-hot write-select vector from the 4-to-16 decoder; bit k selects register k.
wr_data  input  N  data to write.
rd_addr0  input  4  read port 0 address.
rd_addr1  input  4  read port 1 address.
rd_data0  output  N  contents of register rd_addr0.
rd_data1  output  N  contents of register rd_addr1.
rd_valid0  output  1  1 when register rd_addr0 has been written since reset.
rd_valid1  output  1  1 when register rd_addr1 has been written since reset.
wr_err  output  1  sticky flag: an illegal write-select was presented.
wr_count  output  8  number of committed writes since reset, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers clear to 0; written bitmap clears to 0; wr_err=0; wr_count=0.
  - Consequently rd_data0/1=0 and rd_valid0/1=0 while rst=0.
- Write legality, evaluated on each rising clk with rst=1:
  - Legal: wr_ena=1 and wr_sel has exactly one bit set.
  - wr_ena=0: no write, no error, wr_sel is ignored.
  - wr_ena=1 and wr_sel==0: no write, no error. This matches the decoder output when the decoder enable is low.
  - wr_ena=1 and popcount(wr_sel)>=2: no register changes, wr_err sets to 1 on that edge and holds until reset, wr_count unchanged.
- Committed write (legal, selected register k):
  - reg[k] <= wr_data.
  - written[k] <= 1.
  - wr_count increments by 1, saturating at 255.
- Register 0 when ZERO_REG=1:
  - A legal write with wr_sel=16'h0001 is accepted: no error, wr_count increments.
  - reg[0] stays 0 and written[0] stays 0.
  - rd_data for address 0 is always 0 and rd_valid for address 0 is always 0.
- Reads:
  - Combinational from stored state; no clock latency.
  - rd_data reflects the pre-edge value in the write cycle and the new value from the cycle after the write.
  - Both ports may read the same address simultaneously.
- Latency:
  - Write to read visibility is 1 cycle; wr_count and the written bitmap also update at the write edge.
  - wr_err rises at the edge that samples the illegal vector.
- Reset mid-operation: asserting rst on any cycle discards any in-flight write; the edge coincident with rst=0 never commits.
- Registers are a flat unpacked array; no X may propagate to any output after reset.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When the committing write's selected register k (legal, rst=1, and not register 0 when ZERO_REG=1) matches rd_addrX in the same cycle, rd_dataX = wr_data and rd_validX = 1 combinationally, before the edge.
  - This gives 0-cycle write-to-read forwarding for the CPU's writeback/decode overlap.
- Undefined:
  - No forwarding; reads always return stored state as described above.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset then read: rst=0 for 2 cycles, release, rd_addr0=5, rd_addr1=15 -> rd_data0=rd_data1=0, rd_valid0=rd_valid1=0, wr_err=0, wr_count=0.
- Legal write and readback: wr_ena=1, wr_sel=16'h0020, wr_data=32'hDEADBEEF, rd_addr0=5:
  - During the write cycle: rd_data0=0 (bypass off) or 32'hDEADBEEF (bypass on).
  - Next cycle: rd_data0=32'hDEADBEEF, rd_valid0=1, wr_count=1.
- Illegal select: wr_ena=1, wr_sel=16'h0030, wr_data=32'h12345678 -> registers 4 and 5 unchanged, wr_err=1 and stays 1 through 3 further legal writes, wr_count does not increment for the illegal cycle.
- Zero register: ZERO_REG=1, write wr_sel=16'h0001, wr_data=32'hFFFFFFFF -> rd_data for address 0 = 0, rd_valid=0, wr_count increments, wr_err=0. With ZERO_REG=0 the same stimulus reads back 32'hFFFFFFFF with valid=1.
- No-op selects: wr_ena=1 with wr_sel=0, and wr_ena=0 with wr_sel=16'hFFFF -> no register change, wr_err=0, wr_count unchanged.
- Saturation and async reset: 300 legal writes -> wr_count=255. Then assert rst mid-cycle, between clk edges -> all outputs go to 0 immediately, before the next clk edge.
